// File: rtl/vrased_pkg.sv
// Shared definitions for the VRASED reset controller.
// Holds the controller state encoding, the default reset-vector address and
// the bit positions of each violation source inside viol / rst_cause.
package vrased_pkg;

   // Controller states: armed and waiting, stretching a reset, or waiting
   // for the CPU to come back through its reset vector.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      HOLD     = 2'd1,
      WAIT_VEC = 2'd2
   } state_t;

   // Address the CPU fetches first after a PUC.
   localparam logic [15:0] RESET_HANDLER_DEFAULT = 16'hFFFE;

   // Violation source bit positions.
   localparam int CAUSE_SDATA_ACCESS = 0;   // unauthorised SDATA access
   localparam int CAUSE_SROM_WRITE   = 1;   // SROM write outside allowed regions
   localparam int CAUSE_CTR_WRITE    = 2;   // CTR write from outside SROM
   localparam int CAUSE_KEY_ACCESS   = 3;   // key ROM access

endpackage

// File: rtl/vrased_hold_timer.sv
// 8-bit hold timer for the VRASED reset controller.
// Loads load_val when load is high, otherwise counts down and stops at zero.
// Ports:
//   clk      - system clock
//   reset_n  - asynchronous active-low reset (counter cleared to 0)
//   load     - load the counter with load_val this cycle
//   load_val - reload value
//   zero     - counter currently equals 0
module vrased_hold_timer (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic       zero
);

   logic [7:0] count;

   // Load has priority so a fresh violation always restarts the period;
   // otherwise the counter parks at zero until the next load.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= 8'd0;
      end else if (load) begin
         count <= load_val;
      end else if (count != 8'd0) begin
         count <= count - 8'd1;
      end
   end

   assign zero = (count == 8'd0);

endmodule

// File: rtl/vrased_reset_ctrl.sv
// VRASED reset controller.
// Turns monitor violation requests into a stretched CPU reset (PUC) pulse,
// then waits for the CPU to fetch its reset vector before re-arming. Also
// keeps a sticky cause register and a saturating violation counter that
// software reads after reboot.
// Ports:
//   clk       - system clock
//   reset_n   - asynchronous active-low reset
//   viol      - per-source violation requests (level or pulse)
//   pc        - current CPU program counter
//   cause_clr - software clear of rst_cause (only honoured while armed)
//   puc_req   - registered CPU reset request, active-high
//   armed     - high while idle and ready for a new violation
//   rst_cause - sticky OR of all sources seen since the last clear
//   viol_cnt  - saturating count of reset episodes entered
module vrased_reset_ctrl
   import vrased_pkg::*;
#(
   parameter int          HOLD_CYCLES   = 16,
   parameter logic [15:0] RESET_HANDLER = RESET_HANDLER_DEFAULT,
   parameter int          NSRC          = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [NSRC-1:0] viol,
   input  logic [15:0]     pc,
   input  logic            cause_clr,
   output logic            puc_req,
   output logic            armed,
   output logic [NSRC-1:0] rst_cause,
   output logic [7:0]      viol_cnt
);

   // The timer holds the number of extra cycles still to spend in HOLD, so
   // an isolated violation gives exactly HOLD_CYCLES cycles of puc_req.
   localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

   state_t state;
   state_t next_state;
   logic   any_viol;
   logic   timer_zero;
   logic   cnt_inc;

   assign any_viol = |viol;

   vrased_hold_timer u_hold_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (any_viol),
      .load_val (HOLD_LOAD),
      .zero     (timer_zero)
   );

   // Next-state logic. A violation forces HOLD from every state, which also
   // gives it priority over the reset-vector fetch in WAIT_VEC.
   always_comb begin
      next_state = state;
      cnt_inc    = 1'b0;
      case (state)
         IDLE: begin
            if (any_viol) begin
               next_state = HOLD;
               cnt_inc    = 1'b1;
            end
         end
         HOLD: begin
            if (!any_viol && timer_zero) begin
               next_state = WAIT_VEC;
            end
         end
         WAIT_VEC: begin
            if (any_viol) begin
               next_state = HOLD;
               cnt_inc    = 1'b1;
            end else if (pc == RESET_HANDLER) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // State and registered outputs. puc_req and armed are decoded from the
   // next state so they change on the same edge as the state itself while
   // staying pure flop outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         puc_req <= 1'b0;
         armed   <= 1'b1;
      end else begin
         state   <= next_state;
         puc_req <= (next_state == HOLD);
         armed   <= (next_state == IDLE);
      end
   end

   // Cause register: sticky in every state. A clear is only accepted while
   // idle so the cause of an in-flight reset cannot be lost; a clear that
   // coincides with a violation keeps that violation.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rst_cause <= '0;
      end else if (cause_clr && (state == IDLE)) begin
         rst_cause <= viol;
      end else begin
         rst_cause <= rst_cause | viol;
      end
   end

   // Episode counter: counts entries into HOLD only, not reloads within it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         viol_cnt <= 8'd0;
      end else if (cnt_inc && (viol_cnt != 8'hFF)) begin
         viol_cnt <= viol_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_vrased_reset_ctrl.sv
// Self-checking bench for vrased_reset_ctrl.
// A behavioural model tracks remaining reset cycles, whether the CPU still
// owes a reset-vector fetch, the sticky cause and the episode count; every
// cycle the DUT outputs are compared against it, and directed scenarios pin
// literal values at key points.
module tb_vrased_reset_ctrl;

   localparam int          HOLD = 16;
   localparam logic [15:0] VEC  = 16'hFFFE;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  viol = 4'h0;
   logic [15:0] pc = 16'h0000;
   logic        cause_clr = 1'b0;
   logic        puc_req;
   logic        armed;
   logic [3:0]  rst_cause;
   logic [7:0]  viol_cnt;

   int vectors = 0;
   int miscompares = 0;

   // Model state
   int         m_hold_left = 0;
   bit         m_waiting = 1'b0;
   logic [3:0] m_cause = 4'h0;
   int         m_cnt = 0;

   vrased_reset_ctrl #(
      .HOLD_CYCLES   (HOLD),
      .RESET_HANDLER (VEC),
      .NSRC          (4)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .viol      (viol),
      .pc        (pc),
      .cause_clr (cause_clr),
      .puc_req   (puc_req),
      .armed     (armed),
      .rst_cause (rst_cause),
      .viol_cnt  (viol_cnt)
   );

   always #5 clk = ~clk;

   // Behavioural model: a violation restarts a HOLD-cycle reset window and
   // leaves the CPU owing a vector fetch; the fetch only counts once the
   // window has ended. Episodes are counted when a violation arrives while
   // no reset window is open.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_hold_left = 0;
         m_waiting   = 1'b0;
         m_cause     = 4'h0;
         m_cnt       = 0;
      end else begin
         if (cause_clr && !m_waiting) m_cause = viol;
         else                         m_cause = m_cause | viol;
         if (viol != 4'h0) begin
            if (m_hold_left == 0 && m_cnt < 255) m_cnt = m_cnt + 1;
            m_hold_left = HOLD;
            m_waiting   = 1'b1;
         end else if (m_hold_left > 0) begin
            m_hold_left = m_hold_left - 1;
         end else if (m_waiting && pc == VEC) begin
            m_waiting = 1'b0;
         end
      end
   end

   task automatic checkValue(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (reset_n) begin
         checkValue("model puc_req", int'(puc_req), int'(m_hold_left > 0));
         checkValue("model armed", int'(armed), int'(!m_waiting));
         checkValue("model rst_cause", int'(rst_cause), int'(m_cause));
         checkValue("model viol_cnt", int'(viol_cnt), m_cnt);
      end
   end

   task automatic checkOutput(input string name, input logic e_puc, input logic e_armed,
                              input logic [3:0] e_cause, input logic [7:0] e_cnt);
      checkValue({name, " puc_req"}, int'(puc_req), int'(e_puc));
      checkValue({name, " armed"}, int'(armed), int'(e_armed));
      checkValue({name, " rst_cause"}, int'(rst_cause), int'(e_cause));
      checkValue({name, " viol_cnt"}, int'(viol_cnt), int'(e_cnt));
   endtask

   // Drive one cycle of inputs and return just after the sampling edge.
   task automatic applyStimulus(input logic [3:0] v, input logic [15:0] p, input logic clr);
      viol      = v;
      pc        = p;
      cause_clr = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic pulseReset();
      @(negedge clk);
      reset_n = 1'b0;
      viol = 4'h0; pc = 16'h0; cause_clr = 1'b0;
      #12;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int pulses;

      // Power-on reset
      #22;
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      checkOutput("por", 1'b0, 1'b1, 4'h0, 8'h00);

      // Isolated single-cycle violation: 16 cycles of puc_req, then WAIT_VEC
      pulses = 0;
      applyStimulus(4'b0001, 16'h0, 1'b0);
      if (puc_req) pulses++;
      for (int i = 0; i < 29; i++) begin
         applyStimulus(4'b0000, 16'h0, 1'b0);
         if (puc_req) pulses++;
      end
      checkValue("single pulse length", pulses, 16);
      checkOutput("single wait_vec", 1'b0, 1'b0, 4'h1, 8'h01);
      applyStimulus(4'b0000, VEC, 1'b0);
      checkOutput("single rearm", 1'b0, 1'b1, 4'h1, 8'h01);

      // Retrigger on HOLD cycle 10: 26 cycles total, no extra count
      pulseReset();
      pulses = 0;
      applyStimulus(4'b0001, 16'h0, 1'b0);
      if (puc_req) pulses++;
      for (int i = 0; i < 9; i++) begin
         applyStimulus(4'b0000, 16'h0, 1'b0);
         if (puc_req) pulses++;
      end
      applyStimulus(4'b0010, 16'h0, 1'b0);
      if (puc_req) pulses++;
      for (int i = 0; i < 25; i++) begin
         applyStimulus(4'b0000, 16'h0, 1'b0);
         if (puc_req) pulses++;
      end
      checkValue("retrigger pulse length", pulses, 26);
      checkOutput("retrigger wait_vec", 1'b0, 1'b0, 4'h3, 8'h01);

      // Violation and vector fetch together in WAIT_VEC: violation wins
      applyStimulus(4'b0100, VEC, 1'b0);
      checkOutput("race", 1'b1, 1'b0, 4'h7, 8'h02);

      // cause_clr ignored in HOLD
      applyStimulus(4'b0000, 16'h0, 1'b1);
      checkOutput("clr in hold", 1'b1, 1'b0, 4'h7, 8'h02);
      for (int i = 0; i < 20; i++) applyStimulus(4'b0000, VEC, 1'b0);
      checkOutput("back to idle", 1'b0, 1'b1, 4'h7, 8'h02);

      // cause_clr honoured in IDLE, and clear-then-OR with a coincident violation
      applyStimulus(4'b0000, 16'h0, 1'b1);
      checkOutput("clr in idle", 1'b0, 1'b1, 4'h0, 8'h02);
      applyStimulus(4'b1000, 16'h0, 1'b1);
      checkOutput("clr with viol", 1'b1, 1'b0, 4'h8, 8'h03);
      for (int i = 0; i < 20; i++) applyStimulus(4'b0000, VEC, 1'b0);
      checkOutput("idle after clr", 1'b0, 1'b1, 4'h8, 8'h03);

      // Saturation of the episode counter
      for (int n = 0; n < 260; n++) begin
         applyStimulus(4'b0001, VEC, 1'b0);
         for (int i = 0; i < 19; i++) applyStimulus(4'b0000, VEC, 1'b0);
      end
      checkOutput("saturated", 1'b0, 1'b1, 4'h9, 8'hFF);

      // Asynchronous reset in the middle of HOLD, checked before the next edge
      applyStimulus(4'b0010, 16'h0, 1'b0);
      applyStimulus(4'b0000, 16'h0, 1'b0);
      applyStimulus(4'b0000, 16'h0, 1'b0);
      checkOutput("mid hold", 1'b1, 1'b0, 4'hB, 8'hFF);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("async reset", 1'b0, 1'b1, 4'h0, 8'h00);
      @(negedge clk);
      reset_n = 1'b1;
      applyStimulus(4'b0000, 16'h0, 1'b0);
      checkOutput("after async reset", 1'b0, 1'b1, 4'h0, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
